pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
Multi-channel PWM generator, parametrised successor to the fixed 32-bit 4-channel PWM peripheral. Adds configurable counter width, edge- or center-aligned mode per channel, output polarity, shadowed period/compare registers reloaded only at period boundaries, register readback and sticky period-end flags. Sits on the peripheral bus with the same write-strobe interface as the other perips.

Parameters:
CHANNELS, 4, number of PWM channels (1..16)
CNT_W, 16, counter/period/compare width in bits (8..32)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
data_i  in  32  write data
addr_i  in  32  address; addr_i[23:16] = {grp[3:0], idx[3:0]} selects the register
we_i  in  1  write strobe, one write per cycle
data_o  out  32  combinational readback of the addressed register, zero-extended
pwm_o  out  CHANNELS  registered PWM outputs

Behaviour:
- Interface: one clock clk_i; reset rst_ni is synchronous, active-low.
- Register map, grp/idx:
  - 0/n: PERIOD staged, channel n.
  - 1/n: COMPARE staged, channel n.
  - 2/0: EN.
  - 2/1: POL.
  - 2/2: MODE (1 = center-aligned).
  - 2/3: STATUS, write-1-to-clear.
  - EN/POL/MODE/STATUS use bits [CHANNELS-1:0].
  - n >= CHANNELS or any unmapped address: writes ignored, reads 0.
  - Writes take data_i[CNT_W-1:0] or data_i[CHANNELS-1:0].
- Readback returns staged values, never active copies.
- Reset: all registers, counters, active copies and STATUS go to 0. pwm_o = 0.
- Per channel: active_period/active_cmp (CNT_W bits), counter cnt (CNT_W bits), direction bit dir.
- Disabled (EN[i]=0):
  - cnt = 0, dir = up.
  - Active copies are reloaded from staged every cycle.
  - pwm_o[i] <= POL[i] (inactive level).
- Edge mode, enabled:
  - cnt counts 0..active_period, then wraps to 0.
  - Boundary = cycle with cnt == active_period.
- Center mode, enabled, active_period >= 1:
  - Up 0..active_period, then down active_period-1..1, then repeat from 0. Period = 2*P cycles.
  - Boundary = cycle where cnt == 1 and dir = down, or P == 1 and cnt == 1.
  - Center mode with P == 0 behaves as edge mode.
- At a boundary the next cycle's active copies load from staged; the in-progress period is never altered.
- Output, registered one cycle after cnt: pwm_o[i] <= (cnt < active_cmp) XOR POL[i].
  - Edge: high CMP cycles of P+1; CMP > P gives constant active.
  - Center: 2*CMP-1 active cycles of 2P for 1 <= CMP <= P; 0 for CMP = 0; all for CMP > P.
- Enable edge: first enabled cycle has cnt = 0 with active copies from the last disabled cycle. pwm_o follows 1 cycle later.
- EN clear: next cycle cnt = 0; one cycle after that, pwm_o = POL.
- MODE/POL written while enabled take effect immediately; software changes MODE only while disabled.
- STATUS[i] is set at each boundary while enabled. A W1C write and a set in the same cycle: set wins.
- Arithmetic is unsigned at CNT_W bits; no counter ever exceeds active_period.
- Reset mid-period: everything returns to reset state on the next edge, pwm_o = 0.

Optional Feature:
PWM_IRQ_EN
- Defined: adds register 2/4 IRQ_MASK (CHANNELS bits, reset 0) and output port irq_o (1 bit, registered).
  - irq_o <= |(STATUS & IRQ_MASK).
  - Level held until STATUS is cleared.
- Undefined: no irq_o port, 2/4 reads 0, writes to it are ignored.

Test Plan:
- Edge: PERIOD0=4, COMPARE0=2, EN=1 -> pwm_o[0] repeats 2 cycles high, 3 low. STATUS[0] sets every 5 cycles.
- Center: MODE0=1, PERIOD0=4, COMPARE0=2, EN=1 -> period 8: 3 high, 5 low. COMPARE0=5 -> constant high. COMPARE0=0 -> constant low.
- Shadow: edge P=4, C=1 running; write COMPARE0=4 mid-period -> current period keeps 1 high; next period 4 high, 1 low. Readback of 1/0 returns 4 immediately.
- Polarity/disable: POL0=1 with channel disabled -> pwm_o[0]=1. Enable with C=2, P=4 -> 2 low, 3 high. Clear EN -> pwm_o[0]=1 two cycles later.
- STATUS: let a boundary set STATUS[1]; write 2/3 = 0x2 in the same cycle as the next boundary -> STATUS[1] remains 1. Write 0x2 on a non-boundary cycle -> clears. With PWM_IRQ_EN and IRQ_MASK=0x2, irq_o tracks it one cycle later.
- Reset: assert rst_ni low mid-period for 1 cycle -> next cycle pwm_o=0, all reads 0, cnt restarts at 0 after re-enable. Write to 0/15 with CHANNELS=4 -> no effect, reads 0.

Source files
------------

// File: rtl/pwm_ctrl.sv
// rtl/pwm_ctrl.sv - multi-channel PWM with shadowed period/compare, edge/center modes
// Define PWM_IRQ_EN to add IRQ_MASK (2/4) and the irq_o output.
module pwm_ctrl #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         data_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  output logic [31:0]         data_o,
`ifdef PWM_IRQ_EN
  output logic                irq_o,
`endif
  output logic [CHANNELS-1:0] pwm_o
);

  localparam logic [3:0] GRP_PERIOD = 4'd0;
  localparam logic [3:0] GRP_CMP    = 4'd1;
  localparam logic [3:0] GRP_CTRL   = 4'd2;
  localparam logic [3:0] IDX_EN     = 4'd0;
  localparam logic [3:0] IDX_POL    = 4'd1;
  localparam logic [3:0] IDX_MODE   = 4'd2;
  localparam logic [3:0] IDX_STATUS = 4'd3;
`ifdef PWM_IRQ_EN
  localparam logic [3:0] IDX_IRQ_MASK = 4'd4;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] grp;
  logic [3:0] idx;
  logic       unused_bits;

  assign grp         = addr_i[23:20];
  assign idx         = addr_i[19:16];
  assign unused_bits = ^{addr_i[31:24], addr_i[15:0], data_i};

  logic [CNT_W-1:0] period_stg_q [CHANNELS];
  logic [CNT_W-1:0] period_stg_d [CHANNELS];
  logic [CNT_W-1:0] cmp_stg_q    [CHANNELS];
  logic [CNT_W-1:0] cmp_stg_d    [CHANNELS];
  logic [CNT_W-1:0] act_period_q [CHANNELS];
  logic [CNT_W-1:0] act_period_d [CHANNELS];
  logic [CNT_W-1:0] act_cmp_q    [CHANNELS];
  logic [CNT_W-1:0] act_cmp_d    [CHANNELS];
  logic [CNT_W-1:0] cnt_q        [CHANNELS];
  logic [CNT_W-1:0] cnt_d        [CHANNELS];

  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] pol_q, pol_d;
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] status_q, status_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] status_set;
  logic [CHANNELS-1:0] status_clr;
`ifdef PWM_IRQ_EN
  logic [CHANNELS-1:0] irq_mask_q, irq_mask_d;
  logic                irq_q, irq_d;
`endif

  always_comb begin : reg_write
    en_d       = en_q;
    pol_d      = pol_q;
    mode_d     = mode_q;
    status_clr = '0;
`ifdef PWM_IRQ_EN
    irq_mask_d = irq_mask_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      period_stg_d[i] = period_stg_q[i];
      cmp_stg_d[i]    = cmp_stg_q[i];
      if (we_i && idx == i[3:0]) begin
        if (grp == GRP_PERIOD) period_stg_d[i] = data_i[CNT_W-1:0];
        if (grp == GRP_CMP)    cmp_stg_d[i]    = data_i[CNT_W-1:0];
      end
    end
    if (we_i && grp == GRP_CTRL) begin
      case (idx)
        IDX_EN:       en_d       = data_i[CHANNELS-1:0];
        IDX_POL:      pol_d      = data_i[CHANNELS-1:0];
        IDX_MODE:     mode_d     = data_i[CHANNELS-1:0];
        IDX_STATUS:   status_clr = data_i[CHANNELS-1:0];
`ifdef PWM_IRQ_EN
        IDX_IRQ_MASK: irq_mask_d = data_i[CHANNELS-1:0];
`endif
        default: ;
      endcase
    end
  end

  // dir = 1 means counting down; only ever set in center mode with a period >= 2.
  always_comb begin : chan_step
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]        = cnt_q[i];
      dir_d[i]        = dir_q[i];
      act_period_d[i] = act_period_q[i];
      act_cmp_d[i]    = act_cmp_q[i];
      status_set[i]   = 1'b0;
      pwm_d[i]        = pol_q[i];
      if (!en_q[i]) begin
        cnt_d[i]        = '0;
        dir_d[i]        = 1'b0;
        act_period_d[i] = period_stg_q[i];
        act_cmp_d[i]    = cmp_stg_q[i];
      end else begin
        pwm_d[i] = (cnt_q[i] < act_cmp_q[i]) ^ pol_q[i];
        if (mode_q[i] && act_period_q[i] != '0) begin
          if (dir_q[i]) begin
            if (cnt_q[i] == CNT_ONE) begin
              status_set[i] = 1'b1;
              cnt_d[i]      = '0;
              dir_d[i]      = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end else if (cnt_q[i] == act_period_q[i]) begin
            if (act_period_q[i] == CNT_ONE) begin
              status_set[i] = 1'b1;
              cnt_d[i]      = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
              dir_d[i] = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end else begin
          dir_d[i] = 1'b0;
          if (cnt_q[i] == act_period_q[i]) begin
            status_set[i] = 1'b1;
            cnt_d[i]      = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        if (status_set[i]) begin
          act_period_d[i] = period_stg_q[i];
          act_cmp_d[i]    = cmp_stg_q[i];
        end
      end
    end
    // A boundary in the same cycle as a W1C keeps the flag set.
    status_d = (status_q & ~status_clr) | status_set;
  end

`ifdef PWM_IRQ_EN
  always_comb begin : irq_calc
    irq_d = |(status_q & irq_mask_q);
  end
  assign irq_o = irq_q;
`endif

  always_comb begin : readback
    data_o = '0;
    case (grp)
      GRP_PERIOD: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx == i[3:0]) data_o = 32'(period_stg_q[i]);
        end
      end
      GRP_CMP: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx == i[3:0]) data_o = 32'(cmp_stg_q[i]);
        end
      end
      GRP_CTRL: begin
        case (idx)
          IDX_EN:       data_o = 32'(en_q);
          IDX_POL:      data_o = 32'(pol_q);
          IDX_MODE:     data_o = 32'(mode_q);
          IDX_STATUS:   data_o = 32'(status_q);
`ifdef PWM_IRQ_EN
          IDX_IRQ_MASK: data_o = 32'(irq_mask_q);
`endif
          default:      data_o = '0;
        endcase
      end
      default: data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_stg_q[i] <= '0;
        cmp_stg_q[i]    <= '0;
        act_period_q[i] <= '0;
        act_cmp_q[i]    <= '0;
        cnt_q[i]        <= '0;
      end
      dir_q    <= '0;
      en_q     <= '0;
      pol_q    <= '0;
      mode_q   <= '0;
      status_q <= '0;
      pwm_q    <= '0;
`ifdef PWM_IRQ_EN
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_stg_q[i] <= period_stg_d[i];
        cmp_stg_q[i]    <= cmp_stg_d[i];
        act_period_q[i] <= act_period_d[i];
        act_cmp_q[i]    <= act_cmp_d[i];
        cnt_q[i]        <= cnt_d[i];
      end
      dir_q    <= dir_d;
      en_q     <= en_d;
      pol_q    <= pol_d;
      mode_q   <= mode_d;
      status_q <= status_d;
      pwm_q    <= pwm_d;
`ifdef PWM_IRQ_EN
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb/tb_pwm_ctrl.sv - scoreboard bench for pwm_ctrl against a period-position model
module tb_pwm_ctrl;
  localparam int CH = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic [31:0]   rdata;
  logic [CH-1:0] pwm;
`ifdef PWM_IRQ_EN
  logic          irq;
`endif

  pwm_ctrl #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data),
    .addr_i (addr),
    .we_i   (we),
    .data_o (rdata),
`ifdef PWM_IRQ_EN
    .irq_o  (irq),
`endif
    .pwm_o  (pwm)
  );

  always #5 clk = ~clk;

  // Model: each enabled channel is a position within a period of length L.
  int unsigned   stg_p [CH];
  int unsigned   stg_c [CH];
  int unsigned   act_p [CH];
  int unsigned   act_c [CH];
  int unsigned   pos   [CH];
  logic [CH-1:0] m_en, m_pol, m_mode, m_status, m_mask, m_pwm;
  logic          m_irq;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic [31:0]   rd;
    logic [31:0]   a;
    logic          irq;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit centered(int c);
    return m_mode[c] && act_p[c] != 0;
  endfunction

  function automatic int unsigned per_len(int c);
    return centered(c) ? 2 * act_p[c] : act_p[c] + 1;
  endfunction

  // Counter value seen at a position: triangle in center mode, ramp otherwise.
  function automatic int unsigned level(int c);
    if (centered(c) && pos[c] > act_p[c]) return 2 * act_p[c] - pos[c];
    return pos[c];
  endfunction

  function automatic bit at_boundary(int c);
    return m_en[c] && pos[c] == per_len(c) - 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int g;
    int i;
    g = int'(a[23:20]);
    i = int'(a[19:16]);
    if (g == 0 && i < CH) return stg_p[i];
    if (g == 1 && i < CH) return stg_c[i];
    if (g == 2) begin
      case (i)
        0: return 32'(m_en);
        1: return 32'(m_pol);
        2: return 32'(m_mode);
        3: return 32'(m_status);
`ifdef PWM_IRQ_EN
        4: return 32'(m_mask);
`endif
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] set_b;
    logic [CH-1:0] n_pwm;
    logic [CH-1:0] clr;
    int g;
    int i;
`ifdef PWM_IRQ_EN
    logic n_irq;
`endif
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        stg_p[c] = 0; stg_c[c] = 0; act_p[c] = 0; act_c[c] = 0; pos[c] = 0;
      end
      m_en = '0; m_pol = '0; m_mode = '0; m_status = '0; m_mask = '0;
      m_pwm = '0; m_irq = 1'b0;
      return;
    end
`ifdef PWM_IRQ_EN
    n_irq = |(m_status & m_mask);
`endif
    for (int c = 0; c < CH; c++) begin
      n_pwm[c] = m_en[c] ? ((level(c) < act_c[c]) ^ m_pol[c]) : m_pol[c];
      set_b[c] = at_boundary(c);
      if (!m_en[c] || set_b[c]) begin
        pos[c]   = 0;
        act_p[c] = stg_p[c];
        act_c[c] = stg_c[c];
      end else begin
        pos[c] = pos[c] + 1;
      end
    end
    g = int'(addr[23:20]);
    i = int'(addr[19:16]);
    clr = (we && g == 2 && i == 3) ? data[CH-1:0] : '0;
    m_status = (m_status & ~clr) | set_b;
    if (we) begin
      if (g == 0 && i < CH) stg_p[i] = int'(data[CW-1:0]);
      if (g == 1 && i < CH) stg_c[i] = int'(data[CW-1:0]);
      if (g == 2 && i == 0) m_en   = data[CH-1:0];
      if (g == 2 && i == 1) m_pol  = data[CH-1:0];
      if (g == 2 && i == 2) m_mode = data[CH-1:0];
`ifdef PWM_IRQ_EN
      if (g == 2 && i == 4) m_mask = data[CH-1:0];
`endif
    end
    m_pwm = n_pwm;
`ifdef PWM_IRQ_EN
    m_irq = n_irq;
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (pwm !== e.pwm) begin
        n_fail++;
        $display("FAIL pwm_o t=%0t actual=%h required=%h", $time, pwm, e.pwm);
      end
      n_checks++;
      if (rdata !== e.rd) begin
        n_fail++;
        $display("FAIL data_o addr=%h t=%0t actual=%h required=%h", e.a, $time, rdata, e.rd);
      end
`ifdef PWM_IRQ_EN
      n_checks++;
      if (irq !== e.irq) begin
        n_fail++;
        $display("FAIL irq_o t=%0t actual=%b required=%b", $time, irq, e.irq);
      end
`endif
    end
  end

  function automatic logic [31:0] ra(int g, int i);
    return {8'h00, 4'(g), 4'(i), 16'h0000};
  endfunction

  function automatic logic [31:0] rand_addr();
    int g;
    g = $urandom_range(0, 3);
    return ra(g, (g == 2) ? $urandom_range(0, 6) : $urandom_range(0, 15));
  endfunction

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    we = w; addr = a; data = d;
    e.pwm = m_pwm; e.rd = model_read(a); e.a = a; e.irq = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input int g, input int i, input logic [31:0] d);
    drive(1'b1, ra(g, i), d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, rand_addr(), $urandom);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic find_boundary(input int c, input bit want);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (at_boundary(c) == want) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    if (!ok) $display("FAIL boundary_search ch%0d actual=not_found required=found", c);
  endtask

  task automatic rand_write();
    int k;
    int i;
    logic [31:0] d;
    k = $urandom_range(0, 9);
    d = $urandom;
    if (k <= 2) begin
      wr(0, $urandom_range(0, CH), (d & 32'hFFFF_0000) | 32'($urandom_range(0, 9)));
    end else if (k <= 5) begin
      wr(1, $urandom_range(0, CH), (d & 32'hFFFF_0000) | 32'($urandom_range(0, 11)));
    end else if (k <= 8) begin
      i = $urandom_range(0, 5);
      if (i == 2) d[CH-1:0] = (d[CH-1:0] & ~m_en) | (m_mode & m_en);
      wr(2, i, d);
    end else begin
      wr($urandom_range(3, 15), $urandom_range(0, 15), d);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; data = '0;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b1;
    idle(2);

    wr(0, 0, 4); wr(1, 0, 2); wr(2, 0, 1);
    idle(16);

    wr(2, 0, 0); wr(2, 2, 1); wr(1, 0, 2); wr(2, 0, 1);
    idle(20);
    wr(1, 0, 5); idle(20);
    wr(1, 0, 0); idle(20);
    wr(2, 0, 0); wr(2, 2, 0);

    wr(0, 0, 4); wr(1, 0, 1); wr(2, 0, 1);
    idle(7);
    wr(1, 0, 4);
    drive(1'b0, ra(1, 0), 0);
    idle(15);

    wr(2, 0, 0); wr(2, 1, 1); idle(3);
    wr(1, 0, 2); wr(2, 0, 1); idle(12);
    wr(2, 0, 0); idle(4);
    wr(2, 1, 0);

    wr(0, 1, 3); wr(1, 1, 1); wr(2, 4, 2); wr(2, 0, 2);
    find_boundary(1, 1'b1);
    idle(1);
    find_boundary(1, 1'b1);
    wr(2, 3, 2);
    idle(2);
    find_boundary(1, 1'b0);
    wr(2, 3, 2);
    idle(6);

    wr(0, 0, 4); wr(1, 0, 2); wr(2, 0, 4'hF);
    idle(3);
    reset_pulse();
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 5; i++) drive(1'b0, ra(g, i), 0);
    wr(0, 0, 4); wr(1, 0, 2); wr(2, 0, 1);
    idle(12);

    wr(0, 15, 32'h1234); wr(1, 15, 32'h5678); wr(2, 9, 32'hF);
    drive(1'b0, ra(0, 15), 0);
    drive(1'b0, ra(1, 15), 0);
    drive(1'b0, ra(2, 9), 0);

    repeat (2500) begin
      int r;
      r = $urandom_range(0, 299);
      if (r == 0)       reset_pulse();
      else if (r < 90)  rand_write();
      else              idle(1);
    end

    we = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) $display("FAIL drain actual=%0d required=0", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
